pila_retorno: RTL
=================

PILA_RETORNO -- requirements
Module: pila_retorno

Interface
REQ-001 SHALL have parameter WIDTH, default 10, return-address width in bits (matches the PC).
REQ-002 SHALL have parameter DEPTH, default 8, number of stack entries; legal range 2..64.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port push  input  1  push request from the control unit.
REQ-006 SHALL have port pop  input  1  pop request from the control unit.
REQ-007 SHALL have port d_in  input  WIDTH  return address to store (PC+1 from the fetch path).
REQ-008 SHALL have port d_out  output  WIDTH  current top of stack, feeding the next-PC mux selected by s_stack_mux.
REQ-009 SHALL have port count  output  $clog2(DEPTH+1)  number of valid entries.
REQ-010 SHALL have port empty  output  1  count==0.
REQ-011 SHALL have port full  output  1  count==DEPTH.
REQ-012 SHALL have port ovf  output  1  sticky overflow flag.
REQ-013 SHALL have port unf  output  1  sticky underflow flag.
REQ-014 SHALL have port err_clr  input  1  synchronous clear of ovf/unf.

Function
REQ-015 SHALL decode each cycle to one operation: NOP (neither request), PUSH (push only), POP (pop asserted, with or without push).
REQ-016 SHALL treat push=1 with pop=1 as POP, since the control unit raises both on a JR return.
REQ-017 SHALL, on PUSH with !full, write d_in to entry count and increment count at the edge.
REQ-018 SHALL, on PUSH with full, leave storage and count unchanged and set ovf.
REQ-019 SHALL, on POP with !empty, decrement count at the edge; the popped entry's contents are not cleared.
REQ-020 SHALL, on POP with empty, leave count at 0 and set unf.
REQ-021 SHALL drive d_out combinationally as entry count-1 when !empty and as all zeros when empty; zero-cycle read latency, so a return in the same cycle uses the pre-pop top.
REQ-022 SHALL derive empty and full combinationally from count; occupancy states EMPTY -> PARTIAL on a push, PARTIAL -> FULL when count reaches DEPTH, and the reverse transitions on a pop.
REQ-023 SHALL clear ovf and unf on err_clr; an error event in the same cycle as err_clr wins and sets the flag.
REQ-024 SHALL never wrap count past DEPTH or below 0.

Reset
REQ-025 SHALL on reset low immediately force count=0, ovf=0 and unf=0, giving empty=1, full=0 and d_out=0.
REQ-026 SHALL NOT reset the storage array; contents are masked by count.
REQ-027 SHALL discard any push or pop in flight when reset asserts mid-cycle; the first operation takes effect on the first rising edge after release.

Configuration
REQ-028 SHALL with macro PILA_RETORNO_ERR_EN defined implement ovf, unf and err_clr as specified in REQ-018, REQ-020 and REQ-023.
REQ-029 SHALL without PILA_RETORNO_ERR_EN tie ovf=0 and unf=0 and ignore err_clr; ignore-on-full and ignore-on-empty behaviour is unchanged and ports are always present.

Structure
REQ-030 SHALL place the WIDTH/DEPTH defaults and the operation encoding (NOP=2'b00, PUSH=2'b01, POP=2'b10) in shared package pila_pkg.
REQ-031 SHALL place storage in sub-module pila_mem: DEPTH x WIDTH registers, one synchronous write port and one asynchronous read port. Pointer, flags and decode stay in pila_retorno.

Verification
REQ-032 SHALL cover: reset low, then release -> count=0, empty=1, d_out=0, ovf=0, unf=0.
REQ-033 SHALL cover: push 10'h005, 10'h012, 10'h3FF -> count=3 and d_out=10'h3FF; then pop -> d_out=10'h012 and count=2.
REQ-034 SHALL cover: 8 pushes of values 1..8, then a 9th push of 10'h0AA -> full=1, count=8, d_out=8, ovf=1; err_clr -> ovf=0.
REQ-035 SHALL cover: pop when empty -> count=0, d_out=0, unf=1; without PILA_RETORNO_ERR_EN -> unf=0.
REQ-036 SHALL cover: count=2 with top 10'h012, then push=1, pop=1, d_in=10'h077 -> d_out=10'h012 before the edge; after the edge count=1 and 10'h077 is not stored.
REQ-037 SHALL cover: reset asserted mid-cycle during a push with count=4 -> count=0 immediately; the push is not applied after release.

Source files
------------

// File: rtl/pila_pkg.sv
// pila_pkg: shared defaults and operation encoding for the return-address stack.
// Latency: n/a (types, constants and the request decoder only).
// Backpressure: n/a.
package pila_pkg;

  localparam int PILA_WIDTH_DEF = 10;
  localparam int PILA_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10
  } pila_op_e;

  // A JR return raises push and pop together; pop takes priority so the
  // return address is consumed and the stale PC+1 is never stored.
  function automatic pila_op_e pila_decode(input logic push, input logic pop);
    if (pop) begin
      return OP_POP;
    end else if (push) begin
      return OP_PUSH;
    end else begin
      return OP_NOP;
    end
  endfunction

endpackage

// File: rtl/pila_retorno_if.sv
// pila_retorno_if: control-unit side bundle of the return-address stack.
// Latency: n/a (wiring only).
// Backpressure: none; the master observes full/empty and the sticky error flags.
interface pila_retorno_if
  import pila_pkg::*;
#(
  parameter int WIDTH = PILA_WIDTH_DEF,
  parameter int DEPTH = PILA_DEPTH_DEF
);

  localparam int CW = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] d_in;
  logic             err_clr;
  logic [WIDTH-1:0] d_out;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;

  // Control unit: issues requests, consumes the top of stack and status.
  modport master (
    output push, pop, d_in, err_clr,
    input  d_out, count, empty, full, ovf, unf
  );

  // Stack: accepts requests, presents top of stack and status.
  modport slave (
    input  push, pop, d_in, err_clr,
    output d_out, count, empty, full, ovf, unf
  );

endinterface

// File: rtl/pila_mem.sv
// pila_mem: DEPTH x WIDTH register file, one synchronous write, one asynchronous read.
// Latency: write lands on the rising edge; read is combinational.
// Backpressure: none; the caller only writes in-range addresses.
module pila_mem
  import pila_pkg::*;
#(
  parameter int WIDTH = PILA_WIDTH_DEF,
  parameter int DEPTH = PILA_DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_dat_o
);

  // Storage is deliberately not reset; the owner masks stale entries by count.
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Single write port, updated on the rising edge.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
  end

  assign rd_dat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/pila_retorno.sv
// pila_retorno: hardware return-address stack (optional sticky ovf/unf under PILA_RETORNO_ERR_EN).
// Latency: d_out is combinational from the current top (zero-cycle read); push/pop take effect on the rising edge.
// Backpressure: none; push when full and pop when empty are dropped and, with PILA_RETORNO_ERR_EN, flagged.
module pila_retorno
  import pila_pkg::*;
#(
  parameter int WIDTH = PILA_WIDTH_DEF,
  parameter int DEPTH = PILA_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  pila_retorno_if.slave bus
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam int            AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  pila_op_e         op;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             wr_en;
  logic             ovf_evt;
  logic             unf_evt;
  logic             empty;
  logic             full;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_dat;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  // Next free slot is entry count; the top lives one below it.
  assign wr_addr = AW'(count_q);
  assign rd_addr = AW'(count_q - 1'b1);

  // Decode the request and compute the next occupancy plus error events.
  always_comb begin
    op      = pila_decode(bus.push, bus.pop);
    count_d = count_q;
    wr_en   = 1'b0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    case (op)
      OP_PUSH: begin
        if (full) begin
          ovf_evt = 1'b1;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + 1'b1;
        end
      end
      OP_POP: begin
        if (empty) begin
          unf_evt = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Occupancy pointer; reset empties the stack immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  pila_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_dat_i  (bus.d_in),
    .rd_addr_i (rd_addr),
    .rd_dat_o  (rd_dat)
  );

  assign bus.d_out = empty ? '0 : rd_dat;
  assign bus.count = count_q;
  assign bus.empty = empty;
  assign bus.full  = full;

`ifdef PILA_RETORNO_ERR_EN
  logic ovf_q;
  logic unf_q;

  // Sticky error flags; a new event outranks a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_evt | (ovf_q & ~bus.err_clr);
      unf_q <= unf_evt | (unf_q & ~bus.err_clr);
    end
  end

  assign bus.ovf = ovf_q;
  assign bus.unf = unf_q;
`else
  logic [2:0] unused_err;

  assign unused_err = {bus.err_clr, ovf_evt, unf_evt};
  assign bus.ovf    = 1'b0;
  assign bus.unf    = 1'b0;
`endif

endmodule
